// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller:
// the three stage instructions in, stall/flush/busy/statistics out.
interface hazard_ctrl_if;
  logic [31:0] instr_d;
  logic [31:0] instr_e;
  logic [31:0] instr_m;
  logic        stall;
  logic        flush_e;
  logic        md_busy;
  logic [15:0] stall_cnt;

  modport master (
    output instr_d, instr_e, instr_m,
    input  stall, flush_e, md_busy, stall_cnt
  );

  modport slave (
    input  instr_d, instr_e, instr_m,
    output stall, flush_e, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard detection for a 5-stage MIPS-like pipeline: load-use, branch-operand
// and multiply/divide-unit hazards, plus the MD busy sequencer and stall counter.
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  hazard_ctrl_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic       vld;
    logic [4:0] r;
  } dest_t;

  function automatic logic is_rtype(input logic [31:0] i);
    return i[31:26] == OP_RTYPE;
  endfunction

  function automatic logic is_mult(input logic [31:0] i);
    return is_rtype(i) && (i[5:0] == FN_MULT || i[5:0] == FN_MULTU);
  endfunction

  function automatic logic is_div(input logic [31:0] i);
    return is_rtype(i) && (i[5:0] == FN_DIV || i[5:0] == FN_DIVU);
  endfunction

  function automatic logic is_jr(input logic [31:0] i);
    return is_rtype(i) && i[5:0] == FN_JR;
  endfunction

  function automatic logic is_mt(input logic [31:0] i);
    return is_rtype(i) && (i[5:0] == FN_MTHI || i[5:0] == FN_MTLO);
  endfunction

  function automatic logic is_md_op(input logic [31:0] i);
    return is_mult(i) || is_div(i) || is_mt(i) ||
           (is_rtype(i) && (i[5:0] == FN_MFHI || i[5:0] == FN_MFLO));
  endfunction

  // R-type control/MD instructions write no GPR; $0 is never a destination.
  function automatic dest_t dest_of(input logic [31:0] i);
    dest_t d;
    d.vld = 1'b0;
    d.r   = 5'd0;
    if (is_rtype(i)) begin
      if (!(is_jr(i) || is_mt(i) || is_mult(i) || is_div(i))) begin
        d.vld = 1'b1;
        d.r   = i[15:11];
      end
    end else if (i[31:26] == OP_ADDI || i[31:26] == OP_ORI ||
                 i[31:26] == OP_LUI  || i[31:26] == OP_LW) begin
      d.vld = 1'b1;
      d.r   = i[20:16];
    end else if (i[31:26] == OP_JAL) begin
      d.vld = 1'b1;
      d.r   = 5'd31;
    end
    if (d.r == 5'd0) d.vld = 1'b0;
    return d;
  endfunction

  function automatic logic uses_rs(input logic [31:0] i);
    return is_rtype(i) || i[31:26] == OP_BEQ || i[31:26] == OP_SW ||
           i[31:26] == OP_ADDI || i[31:26] == OP_ORI || i[31:26] == OP_LW;
  endfunction

  function automatic logic uses_rt(input logic [31:0] i);
    return (is_rtype(i) && !is_jr(i) && !is_mt(i)) ||
           i[31:26] == OP_BEQ || i[31:26] == OP_SW;
  endfunction

  function automatic logic reads_reg(input logic [31:0] i, input logic [4:0] r);
    return (uses_rs(i) && i[25:21] == r) || (uses_rt(i) && i[20:16] == r);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [15:0] stall_cnt_r;
  logic        load_use, branch_hz, md_hz, stall_c;
  dest_t       dest_e;

  always_comb begin
    dest_e    = dest_of(bus.instr_e);
    load_use  = bus.instr_e[31:26] == OP_LW && bus.instr_e[20:16] != 5'd0 &&
                reads_reg(bus.instr_d, bus.instr_e[20:16]);
    branch_hz = (bus.instr_d[31:26] == OP_BEQ || is_jr(bus.instr_d)) &&
                ((dest_e.vld && reads_reg(bus.instr_d, dest_e.r)) ||
                 (bus.instr_m[31:26] == OP_LW && bus.instr_m[20:16] != 5'd0 &&
                  reads_reg(bus.instr_d, bus.instr_m[20:16])));
    md_hz     = is_md_op(bus.instr_d) &&
                (state == BUSY || is_mult(bus.instr_e) || is_div(bus.instr_e));
    stall_c   = reset_n && (load_use || branch_hz || md_hz);
  end

  // MD sequencer: starts only from IDLE, so a start seen while BUSY is dropped.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (is_mult(bus.instr_e)) begin
          state_nx = BUSY;
          cnt_nx   = 4'(MULT_CYC);
        end else if (is_div(bus.instr_e)) begin
          state_nx = BUSY;
          cnt_nx   = 4'(DIV_CYC);
        end
      end
      BUSY: begin
        cnt_nx = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nx = IDLE;
          cnt_nx   = 4'd0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      stall_cnt_r <= 16'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (stall_c) stall_cnt_r <= sat_inc(stall_cnt_r);
    end
  end

  assign bus.stall     = stall_c;
  assign bus.flush_e   = stall_c;
  assign bus.md_busy   = (state == BUSY);
  assign bus.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch, MD sequencing, reset abort
// and stall counter saturation, with expected values written out by hand.
module tb_hazard_ctrl;

  localparam logic [31:0] LW_8_9     = 32'h8D280000;
  localparam logic [31:0] ADD_10_8   = 32'h010B5020;
  localparam logic [31:0] ADD_10_12  = 32'h018C5020;
  localparam logic [31:0] BEQ_3_4    = 32'h10640000;
  localparam logic [31:0] ADDI_4     = 32'h20040001;
  localparam logic [31:0] ADDI_0     = 32'h20000001;
  localparam logic [31:0] LW_3_5     = 32'h8CA30000;
  localparam logic [31:0] JR_4       = 32'h00800008;
  localparam logic [31:0] MULT_1_2   = 32'h00220018;
  localparam logic [31:0] MFLO_5     = 32'h00002812;
  localparam logic [31:0] DIV_3_4    = 32'h0064001A;
  localparam logic [31:0] NOP        = 32'h00000000;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;
  logic [15:0] exp_cnt = 16'd0;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one edge; the expected counter follows the stall the bench intends.
  task automatic step(input bit exp_stall);
    if (exp_stall && reset_n && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
    bus.instr_d = d;
    bus.instr_e = e;
    bus.instr_m = m;
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(NOP, NOP, NOP);
    step(0);
    step(0);
    chk("reset_md_busy", bus.md_busy, 0);
    chk("reset_stall_cnt", bus.stall_cnt, 0);
    chk("reset_stall", bus.stall, 0);
    reset_n = 1'b1;

    drive(ADD_10_8, LW_8_9, NOP);
    chk("loaduse_stall", bus.stall, 1);
    chk("loaduse_flush", bus.flush_e, 1);
    step(1);
    drive(ADD_10_12, LW_8_9, NOP);
    chk("loaduse_none", bus.stall, 0);
    step(0);
    chk("cnt_after_loaduse", bus.stall_cnt, exp_cnt);

    drive(BEQ_3_4, ADDI_4, NOP);
    chk("branch_e_dest", bus.stall, 1);
    step(1);
    drive(BEQ_3_4, NOP, LW_3_5);
    chk("branch_m_lw", bus.stall, 1);
    step(1);
    drive(BEQ_3_4, ADDI_0, NOP);
    chk("branch_dest_zero", bus.stall, 0);
    step(0);
    drive(JR_4, ADDI_4, NOP);
    chk("jr_e_dest", bus.stall, 1);
    step(1);
    chk("cnt_after_branch", bus.stall_cnt, exp_cnt);

    drive(BEQ_3_4, LW_3_5, LW_3_5);
    chk("multi_hazard_stall", bus.stall, 1);
    step(1);
    chk("multi_hazard_single_inc", bus.stall_cnt, 16'd5);

    drive(MFLO_5, MULT_1_2, NOP);
    chk("mult_start_busy", bus.md_busy, 0);
    chk("mult_start_stall", bus.stall, 1);
    step(1);
    drive(MFLO_5, NOP, NOP);
    for (int i = 0; i < 5; i++) begin
      chk("mult_busy", bus.md_busy, 1);
      chk("mult_mflo_stall", bus.stall, 1);
      step(1);
    end
    chk("mult_done_busy", bus.md_busy, 0);
    chk("mult_release", bus.stall, 0);
    chk("cnt_after_mult", bus.stall_cnt, exp_cnt);

    drive(DIV_3_4, DIV_3_4, NOP);
    chk("div_start_stall", bus.stall, 1);
    step(1);
    drive(DIV_3_4, NOP, NOP);
    for (int i = 0; i < 10; i++) begin
      chk("div_busy", bus.md_busy, 1);
      chk("div_second_stall", bus.stall, 1);
      step(1);
    end
    chk("div_done_busy", bus.md_busy, 0);
    chk("div_release", bus.stall, 0);
    chk("cnt_after_div", bus.stall_cnt, 16'd22);

    drive(NOP, DIV_3_4, NOP);
    chk("div_nomd_d_stall", bus.stall, 0);
    step(0);
    drive(NOP, NOP, NOP);
    step(0);
    step(0);
    chk("busy_cycle3", bus.md_busy, 1);
    reset_n = 1'b0;
    drive(ADD_10_8, LW_8_9, NOP);
    chk("reset_gates_stall", bus.stall, 0);
    chk("reset_gates_flush", bus.flush_e, 0);
    step(0);
    exp_cnt = 16'd0;
    chk("abort_md_busy", bus.md_busy, 0);
    chk("abort_stall_cnt", bus.stall_cnt, 0);
    reset_n = 1'b1;
    drive(NOP, NOP, NOP);
    step(0);
    chk("after_abort_idle", bus.md_busy, 0);

    drive(ADD_10_8, LW_8_9, NOP);
    for (int i = 0; i < 65534; i++) step(1);
    chk("sat_near", bus.stall_cnt, 16'hFFFE);
    step(1);
    chk("sat_reach", bus.stall_cnt, 16'hFFFF);
    for (int i = 0; i < 4465; i++) step(1);
    chk("sat_hold", bus.stall_cnt, 16'hFFFF);
    chk("sat_model", bus.stall_cnt, exp_cnt);
    chk("sat_still_stalling", bus.stall, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5, busy cycles for mult/multu (range 1..15).
REQ-002 Parameter DIV_CYC, default 10, busy cycles for div/divu (range 1..15).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 instr_d  input  32  instruction currently in the D pipeline register.
REQ-006 instr_e  input  32  instruction currently in the E pipeline register.
REQ-007 instr_m  input  32  instruction currently in the M pipeline register.
REQ-008 stall  output  1  freeze the PC and the D register this cycle.
REQ-009 flush_e  output  1  load a bubble (all-zero instruction) into the E register at the next edge.
REQ-010 md_busy  output  1  multiply/divide unit occupied.
REQ-011 stall_cnt  output  16  saturating count of stalled cycles.

Function
REQ-012 Decode of each stage SHALL use op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0].
REQ-013 Destination register SHALL be:
- rd for R-type (op 0) ALU ops;
- rt for addi/ori/lui/lw;
- 31 for jal;
- none otherwise.
- Register 0 SHALL never count as a destination.
REQ-014 Source usage SHALL be:
- R-type: rs and rt, except jr and mthi/mtlo, which use rs only;
- beq and sw: rs and rt;
- addi/ori/lw: rs only;
- lui/j/jal: none.
REQ-015 Load-use hazard: SHALL be raised when instr_e is lw (op 0x23) with rt != 0 and instr_d uses rt_e as a source.
REQ-016 Branch hazard: SHALL be raised when instr_d is beq or jr and either of these holds:
- instr_e has a destination equal to a source of instr_d;
- instr_m is lw whose rt equals a source of instr_d.
REQ-017 MD hazard: SHALL be raised when instr_d is mult/multu/div/divu/mfhi/mflo/mthi/mtlo and either md_busy = 1 or instr_e is a mult/multu/div/divu start.
REQ-018 stall SHALL be the combinational OR of REQ-015..017.
- flush_e SHALL equal stall in the same cycle.
- Both SHALL be 0 whenever reset_n = 0.
REQ-019 The MD sequencer SHALL have two states, IDLE and BUSY, and a 4-bit down-counter cnt.
REQ-020 In IDLE, with instr_e = mult/multu (funct 0x18/0x19, op 0), the next edge SHALL load cnt = MULT_CYC and enter BUSY.
REQ-021 In IDLE, with instr_e = div/divu (funct 0x1A/0x1B, op 0), the next edge SHALL load cnt = DIV_CYC and enter BUSY.
REQ-022 In BUSY, cnt SHALL decrement by 1 per edge.
- When cnt = 1, the next edge SHALL enter IDLE with cnt = 0.
REQ-023 An MD start in instr_e while in BUSY SHALL be ignored.
- Under REQ-017 this cannot occur on a legal stream.
REQ-024 md_busy SHALL be 1 exactly while the state is BUSY (registered output).
REQ-025 stall_cnt SHALL increment by 1 on each edge where stall = 1 and saturate at 0xFFFF, with no wrap.
REQ-026 Latency: hazard detection is 0 cycles (combinational from the instr_* inputs); md_busy rises 1 cycle after the MD instruction enters E.
REQ-027 When two hazard sources are active together, the result SHALL be a single stall/flush, with no additional effect.

Reset
REQ-028 On a posedge with reset_n = 0, the block SHALL set state = IDLE, cnt = 0, md_busy = 0 and stall_cnt = 0.
REQ-029 A reset asserted mid-BUSY SHALL abort the operation.
- The first edge after reset_n returns to 1 SHALL see state = IDLE.

Verification
REQ-030 Load-use: instr_e = lw $8,0($9) (0x8D280000) and instr_d = add $10,$8,$11 (0x010B5020) -> stall = 1 and flush_e = 1; with instr_d changed to use $12 only -> stall = 0.
REQ-031 Branch: instr_d = beq $3,$4 and instr_e = addi $4,$0,1 -> stall = 1; with instr_m = lw $3 and instr_e = nop -> stall = 1; with instr_e writing $0 -> stall = 0.
REQ-032 Mult sequencing: instr_e = mult $1,$2, then nops -> md_busy high for exactly 5 cycles starting 1 cycle later; mflo in instr_d stalls during those cycles and releases the cycle md_busy falls.
REQ-033 Div with DIV_CYC = 10: md_busy high for exactly 10 cycles; a second div in instr_d stalls throughout, and stall_cnt increases by 11 (the start cycle plus 10 busy cycles).
REQ-034 Reset mid-BUSY: assert reset_n = 0 at busy cycle 3 -> md_busy = 0, stall_cnt = 0 after the edge; with reset_n low, stall = 0 even with a load-use pattern present.
REQ-035 Saturation: force 70000 stall cycles -> stall_cnt holds at 0xFFFF.
